// File: rtl/dsp_frame_sequencer_if.sv
// rtl/dsp_frame_sequencer_if.sv - handshake, core and status bundle for dsp_frame_sequencer
//
// slave  : the sequencer side (receives frames and core results, drives core and status)
// master : the environment side (sample I/O plus dsp_core)
interface dsp_frame_sequencer_if #(
  parameter int data_width = 16,
  parameter int n_channels = 2
);
  localparam int CH_W = (n_channels > 1) ? $clog2(n_channels) : 1;

  logic                             full_reset;
  logic                             enable;
  logic [n_channels*data_width-1:0] in_frame;
  logic                             in_valid;
  logic                             in_ready;
  logic                             core_tick;
  logic [CH_W-1:0]                  core_channel;
  logic [data_width-1:0]            core_sample_in;
  logic [data_width-1:0]            core_sample_out;
  logic                             core_ready;
  logic [n_channels*data_width-1:0] out_frame;
  logic                             out_valid;
  logic                             error;
  logic [1:0]                       fault_code;
  logic [31:0]                      frames_done;
  logic [15:0]                      overruns;

  modport slave (
    input  full_reset, enable, in_frame, in_valid, core_sample_out, core_ready,
    output in_ready, core_tick, core_channel, core_sample_in, out_frame, out_valid,
    output error, fault_code, frames_done, overruns
  );

  modport master (
    output full_reset, enable, in_frame, in_valid, core_sample_out, core_ready,
    input  in_ready, core_tick, core_channel, core_sample_in, out_frame, out_valid,
    input  error, fault_code, frames_done, overruns
  );
endinterface

// File: rtl/dsp_frame_sequencer.sv
// rtl/dsp_frame_sequencer.sv - frame FIFO plus serial per-channel sequencer in front of dsp_core
//
// Buffers input frames, feeds each channel to the core with a tick/ready handshake,
// collects results and emits one registered output frame per input frame.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   bus (slave)      : full_reset/enable control, in_frame/in_valid/in_ready input side,
//                      core_tick/core_channel/core_sample_in/core_sample_out/core_ready core side,
//                      out_frame/out_valid result side, error/fault_code/frames_done/overruns status
// Optional feature macro: SEQ_WATCHDOG_EN (core-stall watchdog leading to the FAULT state)
module dsp_frame_sequencer #(
  parameter int data_width     = 16,
  parameter int n_channels     = 2,
  parameter int fifo_depth     = 4,
  parameter int timeout_cycles = 4096
) (
  input logic                   clk,
  input logic                   reset,
  dsp_frame_sequencer_if.slave  bus
);
  localparam int FW    = n_channels * data_width;
  localparam int CH_W  = (n_channels > 1) ? $clog2(n_channels) : 1;
  localparam int PTR_W = $clog2(fifo_depth);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_TICK, S_GUARD, S_WAIT, S_DONE, S_FAULT} state_t;
  state_t state_q, state_d;

  logic [FW-1:0]    fifo_mem [fifo_depth];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [FW-1:0]    frame_q, result_q, out_frame_q;
  logic [CH_W-1:0]  ch_q;
  logic             out_valid_q, ovr_seen_q;
  logic [31:0]      frames_done_q;
  logic [15:0]      overruns_q;
  logic             fifo_full, fifo_empty, pop, push, overrun, last_ch, core_done;
  logic             wd_expire, wd_fault, core_tick;

  assign fifo_full  = (count_q == CNT_W'(fifo_depth));
  assign fifo_empty = (count_q == '0);
  assign pop        = (state_q == S_IDLE) && bus.enable && !fifo_empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push       = bus.in_valid && (!fifo_full || pop);
  assign overrun    = bus.in_valid && !push;
  assign last_ch    = (ch_q == CH_W'(n_channels - 1));
  assign core_done  = (state_q == S_WAIT) && bus.core_ready;

`ifdef SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(timeout_cycles + 1);
  logic [WD_W-1:0] wdog_q;
  logic            wd_fault_q;

  // The n-th WAIT cycle sees wdog_q == n-1, so expiry lands exactly timeout_cycles into WAIT.
  assign wd_expire = (state_q == S_WAIT) && !bus.core_ready && (wdog_q == WD_W'(timeout_cycles - 1));
  assign wd_fault  = wd_fault_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_q     <= '0;
      wd_fault_q <= 1'b0;
    end else if (bus.full_reset) begin
      wdog_q     <= '0;
      wd_fault_q <= 1'b0;
    end else begin
      if (state_q == S_TICK)      wdog_q <= '0;
      else if (state_q == S_WAIT) wdog_q <= wdog_q + WD_W'(1);
      if (wd_expire)              wd_fault_q <= 1'b1;
    end
  end
`else
  assign wd_expire = 1'b0;
  assign wd_fault  = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               state_q <= S_IDLE;
    else if (bus.full_reset) state_q <= S_IDLE;
    else                     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pop) state_d = S_TICK;
      S_TICK:  state_d = S_GUARD;
      S_GUARD: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.core_ready) state_d = last_ch ? S_DONE : S_TICK;
        else if (wd_expire) state_d = S_FAULT;
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    core_tick = 1'b0;
    case (state_q)
      S_TICK:  core_tick = 1'b1;
      default: core_tick = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.in_frame;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0; rd_ptr_q <= '0; count_q <= '0;
      frame_q <= '0; result_q <= '0; out_frame_q <= '0; ch_q <= '0;
      out_valid_q <= 1'b0; ovr_seen_q <= 1'b0; frames_done_q <= '0; overruns_q <= '0;
    end else if (bus.full_reset) begin
      wr_ptr_q <= '0; rd_ptr_q <= '0; count_q <= '0;
      frame_q <= '0; result_q <= '0; out_frame_q <= '0; ch_q <= '0;
      out_valid_q <= 1'b0; ovr_seen_q <= 1'b0; frames_done_q <= '0; overruns_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        frame_q  <= fifo_mem[rd_ptr_q];
        ch_q     <= '0;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (overrun) begin
        ovr_seen_q <= 1'b1;
        if (overruns_q != 16'hFFFF) overruns_q <= overruns_q + 16'd1;
      end
      if (core_done) begin
        result_q[int'(ch_q)*data_width +: data_width] <= bus.core_sample_out;
        if (!last_ch) ch_q <= ch_q + CH_W'(1);
      end
      out_valid_q <= (state_q == S_DONE);
      if (state_q == S_DONE) begin
        out_frame_q   <= result_q;
        frames_done_q <= frames_done_q + 32'd1;
      end
    end
  end

  assign bus.in_ready       = !fifo_full;
  assign bus.core_tick      = core_tick;
  assign bus.core_channel   = ch_q;
  assign bus.core_sample_in = frame_q[int'(ch_q)*data_width +: data_width];
  assign bus.out_frame      = out_frame_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.error          = ovr_seen_q | wd_fault;
  assign bus.fault_code     = {wd_fault, ovr_seen_q};
  assign bus.frames_done    = frames_done_q;
  assign bus.overruns       = overruns_q;
endmodule

// File: tb/tb_dsp_frame_sequencer.sv
// tb/tb_dsp_frame_sequencer.sv - scoreboard bench for dsp_frame_sequencer
module tb_dsp_frame_sequencer;
  localparam int CORE_DELAY = 2;

  logic clk = 1'b0;
  logic reset;
  logic core_stall;
  int unsigned core_cnt;
  logic [15:0] core_res;

  int tests = 0;
  int fails = 0;
  int ov_count = 0;
  int ov_snap;
  int tick_log[$];
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;

  // Directed vectors: input frame and hand-computed output (each channel + 1, 16-bit wrap).
  logic [31:0] vin [18] = '{
    32'h0020_0010, 32'h0002_0001, 32'hFFFF_7FFF, 32'h1234_ABCD, 32'h0000_0000, 32'h8000_FFFE,
    32'h000A_0009, 32'h00FF_0100, 32'h5555_AAAA, 32'h0F0F_F0F0, 32'h0004_0003, 32'h0006_0005,
    32'h0008_0007, 32'h7FFF_8000, 32'h0001_FFFF, 32'h3C3C_C3C3, 32'h0BAD_0BAD, 32'h0C0C_0C0C};
  logic [31:0] vexp [18] = '{
    32'h0021_0011, 32'h0003_0002, 32'h0000_8000, 32'h1235_ABCE, 32'h0001_0001, 32'h8001_FFFF,
    32'h000B_000A, 32'h0100_0101, 32'h5556_AAAB, 32'h0F10_F0F1, 32'h0005_0004, 32'h0007_0006,
    32'h0009_0008, 32'h8000_8001, 32'h0002_0000, 32'h3C3D_C3C4, 32'h0BAE_0BAE, 32'h0C0D_0C0D};

  dsp_frame_sequencer_if #(.data_width(16), .n_channels(2)) bus ();

  dsp_frame_sequencer #(
    .data_width(16), .n_channels(2), .fifo_depth(4), .timeout_cycles(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Core model: echoes sample+1; ready stays high through the guard cycle, then low for CORE_DELAY cycles.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      core_cnt <= 0;
      core_res <= '0;
    end else if (bus.core_tick) begin
      core_cnt <= CORE_DELAY + 1;
      core_res <= bus.core_sample_in + 16'd1;
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt - 1;
    end
  end
  assign bus.core_ready      = !core_stall && (core_cnt == 0 || core_cnt == CORE_DELAY + 1);
  assign bus.core_sample_out = core_res;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every out_valid, logs core_tick channels.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.core_tick) tick_log.push_back(int'(bus.core_channel));
      if (bus.out_valid) begin
        ov_count++;
        check("scoreboard_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("out_frame", bus.out_frame, mon_e);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] f);
    bus.in_frame = f;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(posedge clk);
      n++;
    end
    cycles(2);
    check("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1; core_stall = 1'b0;
    bus.full_reset = 1'b0; bus.enable = 1'b1; bus.in_valid = 1'b0; bus.in_frame = '0;
    cycles(2);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_core_tick", bus.core_tick, 0);
    check("rst_core_channel", bus.core_channel, 0);
    check("rst_core_sample_in", bus.core_sample_in, 0);
    check("rst_out_frame", bus.out_frame, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_error", bus.error, 0);
    check("rst_fault_code", bus.fault_code, 0);
    check("rst_frames_done", bus.frames_done, 0);
    check("rst_overruns", bus.overruns, 0);
    reset = 1'b0;
    cycles(1);

    // Single frame, two core passes on channel 0 then 1.
    exp_q.push_back(vexp[0]);
    send(vin[0]);
    drain(100);
    check("t1_frames_done", bus.frames_done, 1);
    check("t1_tick_count", tick_log.size(), 2);
    if (tick_log.size() == 2) begin
      check("t1_tick_ch0", tick_log[0], 0);
      check("t1_tick_ch1", tick_log[1], 1);
    end
    check("t1_out_valid_count", ov_count, 1);

    // Overrun: one frame in flight on a stalled core, then a 5-frame burst drops the last.
    core_stall = 1'b1;
    exp_q.push_back(vexp[1]);
    send(vin[1]);
    cycles(3);
    for (int i = 2; i <= 6; i++) begin
      if (i <= 5) exp_q.push_back(vexp[i]);
      send(vin[i]);
    end
    check("t2_overruns", bus.overruns, 1);
    check("t2_fault_code", bus.fault_code, 2'b01);
    check("t2_error", bus.error, 1);
    check("t2_in_ready_full", bus.in_ready, 0);
    core_stall = 1'b0;
    drain(300);
    check("t2_frames_done", bus.frames_done, 6);

    // Full FIFO with a same-cycle pop and push: the push must land.
    bus.enable = 1'b0;
    for (int i = 7; i <= 10; i++) begin
      exp_q.push_back(vexp[i]);
      send(vin[i]);
    end
    check("t3_in_ready_full", bus.in_ready, 0);
    exp_q.push_back(vexp[11]);
    bus.enable = 1'b1;
    send(vin[11]);
    check("t3_overruns_unchanged", bus.overruns, 1);
    check("t3_still_full", bus.in_ready, 0);
    drain(300);
    check("t3_frames_done", bus.frames_done, 11);

    // enable dropped mid-frame: in-flight frame completes, queued ones wait.
    exp_q.push_back(vexp[12]);
    send(vin[12]);
    send(vin[13]);
    send(vin[14]);
    bus.enable = 1'b0;
    drain(100);
    tick_log.delete();
    ov_snap = ov_count;
    cycles(20);
    check("t4_no_tick_disabled", tick_log.size(), 0);
    check("t4_no_out_disabled", ov_count, ov_snap);
    check("t4_in_ready", bus.in_ready, 1);
    exp_q.push_back(vexp[13]);
    exp_q.push_back(vexp[14]);
    bus.enable = 1'b1;
    drain(200);
    check("t4_tick_count", tick_log.size(), 4);
    check("t4_frames_done", bus.frames_done, 14);

    // Soft reset clears everything, then operation resumes.
    bus.full_reset = 1'b1;
    cycles(1);
    bus.full_reset = 1'b0;
    check("fr_frames_done", bus.frames_done, 0);
    check("fr_overruns", bus.overruns, 0);
    check("fr_fault_code", bus.fault_code, 0);
    check("fr_error", bus.error, 0);
    check("fr_out_frame", bus.out_frame, 0);
    check("fr_in_ready", bus.in_ready, 1);
    exp_q.push_back(vexp[15]);
    send(vin[15]);
    drain(100);
    check("fr_resume_frames_done", bus.frames_done, 1);

`ifdef SEQ_WATCHDOG_EN
    // Watchdog: push at edge 1, WAIT spans edges 4..20, FAULT after edge 20.
    core_stall = 1'b1;
    ov_snap = ov_count;
    send(vin[16]);
    cycles(18);
    check("wd_before_expiry", bus.fault_code, 2'b00);
    cycles(1);
    check("wd_fault_code", bus.fault_code, 2'b10);
    check("wd_error", bus.error, 1);
    core_stall = 1'b0;
    tick_log.delete();
    cycles(20);
    check("wd_no_tick_in_fault", tick_log.size(), 0);
    check("wd_no_out_valid", ov_count, ov_snap);
    bus.full_reset = 1'b1;
    cycles(1);
    bus.full_reset = 1'b0;
    check("wd_fr_fault_code", bus.fault_code, 0);
    check("wd_fr_frames_done", bus.frames_done, 0);
    exp_q.push_back(vexp[16]);
    send(vin[16]);
    drain(100);
    check("wd_resume_frames_done", bus.frames_done, 1);
`endif

    // Asynchronous reset in WAIT: outputs clear between clock edges.
    core_stall = 1'b1;
    send(vin[17]);
    cycles(4);
    check("ar_sample_before", bus.core_sample_in, 16'h0C0C);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("ar_core_sample_in", bus.core_sample_in, 0);
    check("ar_frames_done", bus.frames_done, 0);
    check("ar_out_frame", bus.out_frame, 0);
    check("ar_core_tick", bus.core_tick, 0);
    check("ar_in_ready", bus.in_ready, 1);
    check("ar_error", bus.error, 0);
    @(negedge clk);
    reset = 1'b0;
    core_stall = 1'b0;
    ov_snap = ov_count;
    cycles(20);
    check("ar_no_spurious_out", ov_count, ov_snap);
    check("ar_frames_done_after", bus.frames_done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
